// File: rtl/alu_result_bcd.sv
// alu_result_bcd: converts an 8-bit ALU result into three BCD digits using
// a sequential double-dabble engine (one iteration per clock). Subtraction
// results arrive as a 4-bit magnitude plus a sign bit in Y[4]; every other
// opcode is treated as an unsigned 8-bit value.
//
// Timing for a START accepted at edge k:
//   edge k      : operand captured, accumulator cleared, enter CONV
//   edges k+1..8: one shift-add-3 iteration each
//   edge k+8    : eighth iteration; digits and sign loaded, enter FIN
//   edge k+9    : FIN -> IDLE (DONE high only between k+8 and k+9)
//   edge k+10   : earliest edge at which a new START is accepted
module alu_result_bcd (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] Y,
    input  logic [1:0] OP,
    output logic       BUSY,
    output logic       DONE,
    output logic       NEG,
    output logic [3:0] HUND,
    output logic [3:0] TENS,
    output logic [3:0] ONES
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [2:0] LAST_ITER = 3'd7;

    // Control and datapath state.
    state_e      state_q, state_d;
    logic [7:0]  opnd_q,  opnd_d;     // operand bits still to be shifted in
    logic [11:0] bcd_q,   bcd_d;      // digit accumulator {hund,tens,ones}
    logic        sign_q,  sign_d;     // captured sign, published at FIN
    logic [2:0]  cnt_q,   cnt_d;      // iterations already performed

    // Registered outputs.
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic        neg_q,   neg_d;
    logic [3:0]  hund_q,  hund_d;
    logic [3:0]  tens_q,  tens_d;
    logic [3:0]  ones_q,  ones_d;

    // Result of one double-dabble iteration applied to the current state.
    logic [11:0] bcd_adj;
    logic [19:0] shift_w;
    logic [11:0] bcd_shift;
    logic [7:0]  opnd_shift;

    // One iteration: add 3 to every digit >= 5, then shift {digits,operand} left.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        // The hundreds digit never exceeds 2 for an 8-bit input, so the bit
        // shifted out of bcd_adj[11] is always zero.
        shift_w    = {bcd_adj[10:0], opnd_q, 1'b0};
        bcd_shift  = shift_w[19:8];
        opnd_shift = shift_w[7:0];
    end

    // Next-state and next-output logic for the IDLE/CONV/FIN controller.
    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    if (OP == OP_SUB) begin
                        opnd_d = {4'b0000, Y[3:0]};
                        sign_d = Y[4];
                    end else begin
                        opnd_d = Y;
                        sign_d = 1'b0;
                    end
                    bcd_d   = 12'd0;
                    cnt_d   = 3'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d  = bcd_shift;
                opnd_d = opnd_shift;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == LAST_ITER) begin
                    // Outputs change only here, so intermediate iteration
                    // values never become visible.
                    hund_d  = bcd_shift[11:8];
                    tens_d  = bcd_shift[7:4];
                    ones_d  = bcd_shift[3:0];
                    neg_d   = sign_q;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are decoded from the next state so that they come
        // straight out of flops aligned with the state register.
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    // State and output registers; synchronous reset overrides START.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (RST) begin
            state_q <= IDLE;
            opnd_q  <= 8'd0;
            bcd_q   <= 12'd0;
            sign_q  <= 1'b0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            bcd_q   <= bcd_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            neg_q   <= neg_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign NEG  = neg_q;
    assign HUND = hund_q;
    assign TENS = tens_q;
    assign ONES = ones_q;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Self-checking bench for alu_result_bcd: a cycle-level behavioural model
// (decimal arithmetic, conversion-age counter) is compared against the DUT
// on every falling edge, and directed scenarios pin exact literal results.
module tb_alu_result_bcd;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] y;
    logic [1:0] op;
    logic       busy, done, neg;
    logic [3:0] hund, tens, ones;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    alu_result_bcd dut (
        .CLK   (clk),
        .RST   (rst),
        .START (start),
        .Y     (y),
        .OP    (op),
        .BUSY  (busy),
        .DONE  (done),
        .NEG   (neg),
        .HUND  (hund),
        .TENS  (tens),
        .ONES  (ones)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: age = -1 when idle, else edges since the accepting
    // edge. Result appears when age reaches 8; block is free again after 9.
    int m_age  = -1;
    int m_hund = 0, m_tens = 0, m_ones = 0, m_neg = 0;
    int p_hund = 0, p_tens = 0, p_ones = 0, p_neg = 0;

    always @(posedge clk) begin
        int mag;
        if (rst) begin
            m_age  = -1;
            m_hund = 0; m_tens = 0; m_ones = 0; m_neg = 0;
        end else if (m_age < 0) begin
            if (start) begin
                mag    = (op == 2'b01) ? int'(y[3:0]) : int'(y);
                p_neg  = (op == 2'b01) ? int'(y[4]) : 0;
                p_hund = mag / 100;
                p_tens = (mag / 10) % 10;
                p_ones = mag % 10;
                m_age  = 0;
            end
        end else begin
            m_age++;
            if (m_age == 8) begin
                m_hund = p_hund; m_tens = p_tens; m_ones = p_ones; m_neg = p_neg;
            end else if (m_age == 9) begin
                m_age = -1;
            end
        end
    end

    // Compare every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy, (m_age >= 0) ? 1 : 0);
            check("done", done, (m_age == 8) ? 1 : 0);
            check("neg",  neg,  m_neg);
            check("hund", hund, m_hund);
            check("tens", tens, m_tens);
            check("ones", ones, m_ones);
        end
    end

    // Wait (bounded) until the block is idle.
    task automatic wait_idle();
        int i;
        for (i = 0; i < 30 && busy; i++) @(negedge clk);
        if (busy) check("idle_timeout", busy, 0);
    endtask

    // One START pulse, then check latency and literal digits.
    task automatic run_conv(input string name, input logic [7:0] yv, input logic [1:0] opv,
                            input int eh, input int et, input int eo, input int en);
        int lat;
        wait_idle();
        @(negedge clk);
        y = yv; op = opv; start = 1'b1;
        @(negedge clk);                // after accepting edge k
        start = 1'b0;
        check({name, "_busy_k"}, busy, 1);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, 8);
        check({name, "_hund"}, hund, eh);
        check({name, "_tens"}, tens, et);
        check({name, "_ones"}, ones, eo);
        check({name, "_neg"},  neg,  en);
    endtask

    // START held for 25 cycles; optionally change Y after edge k+3.
    task automatic run_held(input string name, input logic [7:0] yv, input bit chg,
                            input logic [7:0] y2);
        int pulses;
        int first_at, second_at;
        int first_val;
        wait_idle();
        @(negedge clk);
        y = yv; op = 2'b00; start = 1'b1;
        @(negedge clk);
        pulses = 0; first_at = -1; second_at = -1; first_val = -1;
        for (int i = 0; i < 25; i++) begin
            if (chg && i == 3) y = y2;
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    first_at  = i;
                    first_val = int'(hund) * 100 + int'(tens) * 10 + int'(ones);
                end else if (pulses == 2) begin
                    second_at = i;
                    if (!chg) check({name, "_second_val"},
                                    int'(hund) * 100 + int'(tens) * 10 + int'(ones), 30);
                end
            end
            if (i < 24) @(negedge clk);
        end
        start = 1'b0;
        check({name, "_first_val"}, first_val, 30);
        check({name, "_first_at"}, first_at, 8);
        if (!chg) begin
            check({name, "_pulses"}, pulses, 2);
            check({name, "_second_at"}, second_at, 18);
        end
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; y = 8'd0; op = 2'b00;
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_neg",  neg,  0);
        check("rst_digits", {hund, tens, ones}, 12'h000);
        rst = 1'b0;

        run_conv("mul225", 8'd225, 2'b10, 2, 2, 5, 0);
        run_conv("sub_neg", 8'b0001_0011, 2'b01, 0, 0, 3, 1);
        run_conv("add19", 8'b0001_0011, 2'b00, 0, 1, 9, 0);
        run_conv("avg255", 8'd255, 2'b11, 2, 5, 5, 0);
        run_conv("avg0", 8'd0, 2'b11, 0, 0, 0, 0);

        run_held("held30", 8'd30, 1'b0, 8'd0);
        run_held("ychg", 8'd30, 1'b1, 8'd99);
        wait_idle();

        // Reset at edge k+4 of a conversion of 200.
        @(negedge clk);
        y = 8'd200; op = 2'b00; start = 1'b1;
        @(negedge clk);                // after k
        start = 1'b0;
        repeat (3) @(negedge clk);     // after k+3
        rst = 1'b1;
        @(negedge clk);                // after k+4
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_digits", {hund, tens, ones}, 12'h000);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        run_conv("after_abort", 8'd200, 2'b00, 2, 0, 0, 0);

        // START in the same edge as RST is discarded.
        wait_idle();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; y = 8'd77;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", busy, 0);
        @(negedge clk);
        check("rst_start_busy2", busy, 0);

        // Randomised traffic; the compare process checks every cycle.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            y     = 8'($urandom);
            op    = 2'($urandom);
            start = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        wait_idle();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_result_bcd.md
ALU_RESULT_BCD -- requirements
Module: alu_result_bcd

Interface
REQ-001 Parameters: none; the block SHALL be fixed to 8-bit ALU results and 3 BCD digits.
REQ-002 CLK  input  1  single clock; all state SHALL update on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 START  input  1  request to convert the current Y/OP.
REQ-005 Y  input  8  ALU_Core result bus.
REQ-006 OP  input  2  opcode that produced Y (00 add, 01 sub, 10 mul, 11 avg).
REQ-007 BUSY  output  1  conversion in progress; START ignored while high.
REQ-008 DONE  output  1  one-cycle pulse: new digits valid.
REQ-009 NEG  output  1  result negative (subtraction only).
REQ-010 HUND  output  4  BCD hundreds digit.
REQ-011 TENS  output  4  BCD tens digit.
REQ-012 ONES  output  4  BCD ones digit.

Function
REQ-013 FSM states SHALL be IDLE, CONV, FIN; all outputs SHALL be registered.
REQ-014 IDLE, START=1 at edge k: capture operand, clear digit accumulator, iteration count=0, go to CONV.
REQ-015 Operand capture: OP=01 -> magnitude {4'b0000,Y[3:0]}, sign Y[4]; any other OP -> magnitude Y[7:0], sign 0.
REQ-016 CONV: each edge SHALL perform one double-dabble iteration: add 3 to every BCD nibble >=5, then shift {digits,operand} left 1 bit.
REQ-017 After the 8th iteration (edge k+8) the FSM SHALL go to FIN and load HUND/TENS/ONES/NEG in the same edge.
REQ-018 DONE SHALL be 1 only in FIN, i.e. exactly the cycle between edges k+8 and k+9; FIN SHALL always return to IDLE at the next edge.
REQ-019 BUSY SHALL be 1 in CONV and FIN, 0 in IDLE.
REQ-020 START in CONV or FIN SHALL be ignored; no queuing. START held high SHALL retrigger at the first edge spent in IDLE (edge k+10).
REQ-021 Y/OP changes after capture SHALL NOT affect the conversion in progress.
REQ-022 HUND/TENS/ONES/NEG SHALL hold their last values until the next FIN load; they SHALL NOT show intermediate iteration values.
REQ-023 Digit range: HUND 0..2, TENS/ONES 0..9; Y=255 SHALL give 2,5,5 with no overflow.
REQ-024 NEG with magnitude 0 SHALL NOT occur (sign from ALU is 0 when A=B); the block SHALL pass Y[4] through regardless.

Reset
REQ-025 RST=1 SHALL force IDLE, BUSY=0, DONE=0, NEG=0, HUND=TENS=ONES=0, count=0, taking priority over START.
REQ-026 RST during CONV or FIN SHALL abort: no DONE pulse, outputs cleared to 0.
REQ-027 START sampled in the same edge as RST SHALL be discarded.

Verification
REQ-028 Reset: RST=1 one cycle -> BUSY=0, DONE=0, NEG=0, digits 0,0,0.
REQ-029 OP=10, Y=225, START pulse at edge k -> BUSY 1 from k, DONE high only between k+8 and k+9, digits 2,2,5, NEG=0.
REQ-030 OP=01, Y=8'b0001_0011 (2-5) -> digits 0,0,3, NEG=1; same Y with OP=00 -> 0,1,9, NEG=0.
REQ-031 OP=00, Y=30, START held high 25 cycles -> exactly 2 DONE pulses (after edges k+8, k+18), digits 0,3,0 each; Y changed to 99 at k+3 -> first result still 0,3,0.
REQ-032 Y=255 OP=11 -> 2,5,5; then Y=0 -> 0,0,0 with DONE pulse.
REQ-033 RST asserted at edge k+4 of a conversion of Y=200 -> BUSY=0 from k+4, no DONE, digits 0,0,0; next START converts normally.
